// File: rtl/mem_xbar_rr_if.sv
// Purpose: bundles the master-side and slave-side request/grant buses of mem_xbar_rr.
// Latency: none, wires only.
// Backpressure: carried by the gnt signals; masters hold their request until granted.
interface mem_xbar_rr_if #(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // master side
  logic [NB_MASTER-1:0]              m_req_i;
  logic [NB_MASTER*ADDR_WIDTH-1:0]   m_addr_i;
  logic [NB_MASTER-1:0]              m_we_i;
  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i;
  logic [NB_MASTER*DATA_WIDTH-1:0]   m_wdata_i;
  logic [NB_MASTER-1:0]              m_gnt_o;
  logic [NB_MASTER-1:0]              m_rvalid_o;
  logic [NB_MASTER*DATA_WIDTH-1:0]   m_rdata_o;
  logic [NB_MASTER-1:0]              m_err_o;
  // slave side
  logic [NB_SLAVE-1:0]               s_req_o;
  logic [NB_SLAVE*ADDR_WIDTH-1:0]    s_addr_o;
  logic [NB_SLAVE-1:0]               s_we_o;
  logic [NB_SLAVE*DATA_WIDTH/8-1:0]  s_be_o;
  logic [NB_SLAVE*DATA_WIDTH-1:0]    s_wdata_o;
  logic [NB_SLAVE-1:0]               s_gnt_i;
  logic [NB_SLAVE-1:0]               s_rvalid_i;
  logic [NB_SLAVE*DATA_WIDTH-1:0]    s_rdata_i;
  logic [NB_SLAVE-1:0]               s_err_i;

  // crossbar view
  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i
  );

  // environment view: drives master requests and slave responses
  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i
  );
endinterface

// File: rtl/mem_xbar_rr.sv
// Purpose: N-master x M-slave request/grant crossbar, address-decoded, round-robin per slave, locked requests, internal error slave.
// Latency: request->grant 0 cycles when the slave grants at once; responses pass through combinationally.
// Backpressure: masters hold req until gnt; each slave port serves one transaction at a time, losers keep waiting.
module mem_xbar_rr #(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR   = {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF}
) (
  input  logic         clk,
  input  logic         rst,
  mem_xbar_rr_if.slave io_bus
);
  localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_t;

  // per-slave-port state
  state_t              r_state      [NB_SLAVE];
  state_t              w_state_nxt  [NB_SLAVE];
  logic [MW-1:0]       r_owner      [NB_SLAVE];
  logic [MW-1:0]       w_owner_nxt  [NB_SLAVE];
  logic [MW-1:0]       r_rr_ptr     [NB_SLAVE];
  logic [MW-1:0]       w_rr_ptr_nxt [NB_SLAVE];
  logic [NB_MASTER-1:0] r_busy;

  // internal error slave
  logic                r_err_vld;
  logic                w_err_vld_nxt;
  logic [MW-1:0]       r_err_owner;
  logic [MW-1:0]       w_err_owner_nxt;
  logic [MW-1:0]       r_err_ptr;
  logic [MW-1:0]       w_err_ptr_nxt;

  // decode results
  logic [NB_SLAVE-1:0]  w_tgt_oh [NB_MASTER];
  logic [NB_MASTER-1:0] w_unmapped;
  logic [NB_MASTER-1:0] w_cand   [NB_SLAVE];
  logic [NB_MASTER-1:0] w_err_cand;

  // output nets
  logic [NB_MASTER-1:0]            w_m_gnt;
  logic [NB_MASTER-1:0]            w_m_rvalid;
  logic [NB_MASTER-1:0]            w_m_err;
  logic [NB_MASTER*DATA_WIDTH-1:0] w_m_rdata;
  logic [NB_SLAVE-1:0]             w_s_req;
  logic [NB_SLAVE*ADDR_WIDTH-1:0]  w_s_addr;
  logic [NB_SLAVE-1:0]             w_s_we;
  logic [NB_SLAVE*BW-1:0]          w_s_be;
  logic [NB_SLAVE*DATA_WIDTH-1:0]  w_s_wdata;

  // first candidate at or after ptr, wrapping modulo NB_MASTER
  function automatic logic [MW-1:0] f_rr_pick(input logic [NB_MASTER-1:0] cand, input logic [MW-1:0] ptr);
    logic [MW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NB_MASTER; k++) begin
      idx = (int'(ptr) + k) % NB_MASTER;
      if (!found && cand[idx]) begin
        pick  = idx[MW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [MW-1:0] f_next(input logic [MW-1:0] cur);
    int nxt;
    nxt = (int'(cur) + 1) % NB_MASTER;
    return nxt[MW-1:0];
  endfunction

  // address decode (lowest matching slave wins) and per-port candidate masks
  always_comb begin
    logic [ADDR_WIDTH-1:0] v_addr;
    logic                  v_found;
    v_addr  = '0;
    v_found = 1'b0;
    for (int i = 0; i < NB_MASTER; i++) begin
      w_tgt_oh[i] = '0;
      v_addr      = io_bus.m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      v_found     = 1'b0;
      for (int j = 0; j < NB_SLAVE; j++) begin
        // modular offset test: addr in [start,end] without a compare that folds to constant when start is 0
        if (!v_found &&
            ((v_addr - START_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH]) <=
             (END_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH] - START_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH]))) begin
          w_tgt_oh[i][j] = 1'b1;
          v_found        = 1'b1;
        end
      end
      w_unmapped[i] = !v_found;
    end
    for (int j = 0; j < NB_SLAVE; j++) begin
      w_cand[j] = '0;
      for (int i = 0; i < NB_MASTER; i++) begin
        w_cand[j][i] = io_bus.m_req_i[i] & ~r_busy[i] & w_tgt_oh[i][j];
      end
    end
    w_err_cand = io_bus.m_req_i & ~r_busy & w_unmapped;
  end

  // slave-port FSMs and error slave: next state plus all bus outputs, everything quiet during reset
  always_comb begin
    logic [MW-1:0] v_sel;
    logic          v_drive;
    v_sel   = '0;
    v_drive = 1'b0;
    w_m_gnt    = '0;
    w_m_rvalid = '0;
    w_m_err    = '0;
    w_m_rdata  = '0;
    w_s_req    = '0;
    w_s_addr   = '0;
    w_s_we     = '0;
    w_s_be     = '0;
    w_s_wdata  = '0;
    for (int j = 0; j < NB_SLAVE; j++) begin
      w_state_nxt[j]  = r_state[j];
      w_owner_nxt[j]  = r_owner[j];
      w_rr_ptr_nxt[j] = r_rr_ptr[j];
    end
    w_err_vld_nxt   = 1'b0;
    w_err_owner_nxt = r_err_owner;
    w_err_ptr_nxt   = r_err_ptr;

    if (!rst) begin
      for (int j = 0; j < NB_SLAVE; j++) begin
        v_sel   = r_owner[j];
        v_drive = 1'b0;
        case (r_state[j])
          ST_IDLE: begin
            if (|w_cand[j]) begin
              v_sel          = f_rr_pick(w_cand[j], r_rr_ptr[j]);
              v_drive        = 1'b1;
              w_owner_nxt[j] = v_sel;
              w_state_nxt[j] = ST_REQ;
            end
          end
          ST_REQ: begin
            // locked: only the latched owner is presented until granted
            v_drive = 1'b1;
          end
          ST_WAIT_RSP: begin
            if (io_bus.s_rvalid_i[j]) begin
              w_m_rvalid[r_owner[j]] = 1'b1;
              w_m_err[r_owner[j]]    = io_bus.s_err_i[j];
              w_m_rdata[int'(r_owner[j])*DATA_WIDTH +: DATA_WIDTH] = io_bus.s_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
              w_state_nxt[j] = ST_IDLE;
            end
          end
          default: w_state_nxt[j] = ST_IDLE;
        endcase

        if (v_drive) begin
          w_s_req[j] = 1'b1;
          w_s_addr[j*ADDR_WIDTH +: ADDR_WIDTH]  = io_bus.m_addr_i[int'(v_sel)*ADDR_WIDTH +: ADDR_WIDTH];
          w_s_we[j]                             = io_bus.m_we_i[v_sel];
          w_s_be[j*BW +: BW]                    = io_bus.m_be_i[int'(v_sel)*BW +: BW];
          w_s_wdata[j*DATA_WIDTH +: DATA_WIDTH] = io_bus.m_wdata_i[int'(v_sel)*DATA_WIDTH +: DATA_WIDTH];
          if (io_bus.s_gnt_i[j]) begin
            w_m_gnt[v_sel]  = 1'b1;
            w_rr_ptr_nxt[j] = f_next(v_sel);
            w_state_nxt[j]  = ST_WAIT_RSP;
          end
        end
      end

      // error slave: answer last cycle's grant, then take one new unmapped request
      if (r_err_vld) begin
        w_m_rvalid[r_err_owner] = 1'b1;
        w_m_err[r_err_owner]    = 1'b1;
      end
      if (|w_err_cand) begin
        v_sel           = f_rr_pick(w_err_cand, r_err_ptr);
        w_m_gnt[v_sel]  = 1'b1;
        w_err_vld_nxt   = 1'b1;
        w_err_owner_nxt = v_sel;
        w_err_ptr_nxt   = f_next(v_sel);
      end
    end
  end

  // state registers; reset drops anything outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NB_SLAVE; j++) begin
        r_state[j]  <= ST_IDLE;
        r_owner[j]  <= '0;
        r_rr_ptr[j] <= '0;
      end
      r_busy      <= '0;
      r_err_vld   <= 1'b0;
      r_err_owner <= '0;
      r_err_ptr   <= '0;
    end else begin
      for (int j = 0; j < NB_SLAVE; j++) begin
        r_state[j]  <= w_state_nxt[j];
        r_owner[j]  <= w_owner_nxt[j];
        r_rr_ptr[j] <= w_rr_ptr_nxt[j];
      end
      r_busy      <= (r_busy | w_m_gnt) & ~w_m_rvalid;
      r_err_vld   <= w_err_vld_nxt;
      r_err_owner <= w_err_owner_nxt;
      r_err_ptr   <= w_err_ptr_nxt;
    end
  end

  assign io_bus.m_gnt_o    = w_m_gnt;
  assign io_bus.m_rvalid_o = w_m_rvalid;
  assign io_bus.m_rdata_o  = w_m_rdata;
  assign io_bus.m_err_o    = w_m_err;
  assign io_bus.s_req_o    = w_s_req;
  assign io_bus.s_addr_o   = w_s_addr;
  assign io_bus.s_we_o     = w_s_we;
  assign io_bus.s_be_o     = w_s_be;
  assign io_bus.s_wdata_o  = w_s_wdata;

endmodule

// File: tb/tb_mem_xbar_rr.sv
// Purpose: directed bench for mem_xbar_rr, 3 masters x 3 slaves, default address map.
// Latency: inputs applied 1 time unit after posedge, outputs sampled on the negedge of the same cycle.
// Backpressure: slave grants and responses are scripted per cycle in the vector table.
module tb_mem_xbar_rr;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_xbar_rr_if #(.NB_MASTER(3), .NB_SLAVE(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_xbar_rr #(.NB_MASTER(3), .NB_SLAVE(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [31:0] a0, a1, a2;
    logic [2:0]  we, gnt, rvl, serr;
    logic [31:0] rd;
    logic [2:0]  e_gnt, e_rvl, e_err;
    logic [95:0] e_rdata;
    logic [2:0]  e_sreq;
    logic [95:0] e_saddr;
  } vec_t;

  vec_t vt[$];

  localparam logic [95:0] Z   = '0;
  localparam logic [31:0] S1A = 32'h0010_0000;
  localparam logic [31:0] S2A = 32'h1A10_0004;
  localparam logic [31:0] S2B = 32'h1A10_0008;
  localparam logic [31:0] S2C = 32'h1A11_0000;
  localparam logic [31:0] UNM = 32'h8000_0000;
  localparam logic [31:0] UN2 = 32'h9000_0000;

  task automatic add(input logic [2:0] req, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                     input logic [2:0] we, input logic [2:0] gnt, input logic [2:0] rvl, input logic [2:0] serr,
                     input logic [31:0] rd, input logic [2:0] e_gnt, input logic [2:0] e_rvl, input logic [2:0] e_err,
                     input logic [95:0] e_rdata, input logic [2:0] e_sreq, input logic [95:0] e_saddr);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.we = we; v.gnt = gnt; v.rvl = rvl; v.serr = serr; v.rd = rd;
    v.e_gnt = e_gnt; v.e_rvl = e_rvl; v.e_err = e_err; v.e_rdata = e_rdata; v.e_sreq = e_sreq; v.e_saddr = e_saddr;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // slaves that are not responding present junk data and err=1 so mis-routing is visible
  task automatic apply(input vec_t v);
    bus.m_req_i   = v.req;
    bus.m_addr_i  = {v.a2, v.a1, v.a0};
    bus.m_we_i    = v.we;
    bus.m_be_i    = '1;
    bus.m_wdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.s_gnt_i   = v.gnt;
    bus.s_rvalid_i = v.rvl;
    for (int j = 0; j < 3; j++) begin
      bus.s_rdata_i[j*32 +: 32] = v.rvl[j] ? v.rd : 32'hDEAD_DEAD;
      bus.s_err_i[j]            = v.rvl[j] ? v.serr[j] : 1'b1;
    end
  endtask

  task automatic idle_inputs();
    vec_t v;
    v.req = '0; v.a0 = '0; v.a1 = '0; v.a2 = '0; v.we = '0; v.gnt = '0; v.rvl = '0; v.serr = '0; v.rd = '0;
    v.e_gnt = '0; v.e_rvl = '0; v.e_err = '0; v.e_rdata = '0; v.e_sreq = '0; v.e_saddr = '0;
    apply(v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //   req     a0       a1   a2   we      gnt     rvl     serr    rd               e_gnt   e_rvl   e_err   e_rdata                          e_sreq  e_saddr
    // single read, S0 grants immediately, response two cycles later
    add(3'b001, 32'h40,  0,   0,   3'b000, 3'b001, 3'b000, 3'b000, 0,               3'b001, 3'b000, 3'b000, Z,                               3'b001, {64'h0, 32'h40});
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b000, 3'b000, 3'b000, Z,                               3'b000, Z);
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b001, 3'b000, 32'hA5A5_1234,   3'b000, 3'b001, 3'b000, {64'h0, 32'hA5A5_1234},          3'b000, Z);
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b000, 3'b000, 3'b000, Z,                               3'b000, Z);
    // round robin on S1: M0, M1, M2, M0 with one grant per two cycles
    add(3'b111, S1A,     S1A, S1A, 3'b000, 3'b010, 3'b000, 3'b000, 0,               3'b001, 3'b000, 3'b000, Z,                               3'b010, {32'h0, S1A, 32'h0});
    add(3'b111, S1A,     S1A, S1A, 3'b000, 3'b010, 3'b010, 3'b000, 32'h11,          3'b000, 3'b001, 3'b000, {64'h0, 32'h11},                 3'b000, Z);
    add(3'b111, S1A,     S1A, S1A, 3'b000, 3'b010, 3'b000, 3'b000, 0,               3'b010, 3'b000, 3'b000, Z,                               3'b010, {32'h0, S1A, 32'h0});
    add(3'b111, S1A,     S1A, S1A, 3'b000, 3'b010, 3'b010, 3'b000, 32'h22,          3'b000, 3'b010, 3'b000, {32'h0, 32'h22, 32'h0},          3'b000, Z);
    add(3'b111, S1A,     S1A, S1A, 3'b000, 3'b010, 3'b000, 3'b000, 0,               3'b100, 3'b000, 3'b000, Z,                               3'b010, {32'h0, S1A, 32'h0});
    add(3'b111, S1A,     S1A, S1A, 3'b000, 3'b010, 3'b010, 3'b000, 32'h33,          3'b000, 3'b100, 3'b000, {32'h33, 64'h0},                 3'b000, Z);
    add(3'b111, S1A,     S1A, S1A, 3'b000, 3'b010, 3'b000, 3'b000, 0,               3'b001, 3'b000, 3'b000, Z,                               3'b010, {32'h0, S1A, 32'h0});
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b010, 3'b000, 32'h44,          3'b000, 3'b001, 3'b000, {64'h0, 32'h44},                 3'b000, Z);
    // lock on S2: M2 held for three cycles, M0 cannot preempt and waits for M2's response
    add(3'b100, 0,       0,   S2A, 3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b000, 3'b000, 3'b000, Z,                               3'b100, {S2A, 64'h0});
    add(3'b101, S2B,     0,   S2A, 3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b000, 3'b000, 3'b000, Z,                               3'b100, {S2A, 64'h0});
    add(3'b101, S2B,     0,   S2A, 3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b000, 3'b000, 3'b000, Z,                               3'b100, {S2A, 64'h0});
    add(3'b101, S2B,     0,   S2A, 3'b000, 3'b100, 3'b000, 3'b000, 0,               3'b100, 3'b000, 3'b000, Z,                               3'b100, {S2A, 64'h0});
    add(3'b001, S2B,     0,   0,   3'b000, 3'b100, 3'b000, 3'b000, 0,               3'b000, 3'b000, 3'b000, Z,                               3'b000, Z);
    add(3'b001, S2B,     0,   0,   3'b000, 3'b100, 3'b100, 3'b000, 32'hBEEF_0002,   3'b000, 3'b100, 3'b000, {32'hBEEF_0002, 64'h0},          3'b000, Z);
    add(3'b001, S2B,     0,   0,   3'b000, 3'b100, 3'b000, 3'b000, 0,               3'b001, 3'b000, 3'b000, Z,                               3'b100, {S2B, 64'h0});
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b100, 3'b000, 32'hBEEF_0000,   3'b000, 3'b001, 3'b000, {64'h0, 32'hBEEF_0000},          3'b000, Z);
    // unmapped write from M1, then two unmapped masters served round robin by the error slave
    add(3'b010, 0,       UNM, 0,   3'b010, 3'b000, 3'b000, 3'b000, 0,               3'b010, 3'b000, 3'b000, Z,                               3'b000, Z);
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b000, 3'b010, 3'b010, Z,                               3'b000, Z);
    add(3'b101, UNM,     0,   UN2, 3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b100, 3'b000, 3'b000, Z,                               3'b000, Z);
    add(3'b001, UNM,     0,   0,   3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b001, 3'b100, 3'b100, Z,                               3'b000, Z);
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b000, 3'b000, 0,               3'b000, 3'b001, 3'b001, Z,                               3'b000, Z);
    // concurrent M0->S0 and M1->S2, responses on separate cycles with a slave error on S2
    add(3'b011, 32'h100, S2C, 0,   3'b000, 3'b101, 3'b000, 3'b000, 0,               3'b011, 3'b000, 3'b000, Z,                               3'b101, {S2C, 32'h0, 32'h100});
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b100, 3'b100, 32'hCAFE_0002,   3'b000, 3'b010, 3'b010, {32'h0, 32'hCAFE_0002, 32'h0},   3'b000, Z);
    add(3'b000, 0,       0,   0,   3'b000, 3'b000, 3'b001, 3'b000, 32'hCAFE_0000,   3'b000, 3'b001, 3'b000, {64'h0, 32'hCAFE_0000},          3'b000, Z);

    // outputs must stay quiet while reset is held, even with live inputs
    rst = 1'b1;
    idle_inputs();
    #2;
    bus.m_req_i    = 3'b111;
    bus.s_gnt_i    = 3'b111;
    bus.s_rvalid_i = 3'b111;
    bus.s_rdata_i  = {3{32'h5555_AAAA}};
    #1;
    chk("rst_m_gnt",    bus.m_gnt_o,    Z);
    chk("rst_m_rvalid", bus.m_rvalid_o, Z);
    chk("rst_m_rdata",  bus.m_rdata_o,  Z);
    chk("rst_s_req",    bus.s_req_o,    Z);
    chk("rst_s_addr",   bus.s_addr_o,   Z);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vt.size(); k++) begin
      @(posedge clk);
      #1;
      apply(vt[k]);
      @(negedge clk);
      chk($sformatf("v%0d_m_gnt", k),    bus.m_gnt_o,    96'(vt[k].e_gnt));
      chk($sformatf("v%0d_m_rvalid", k), bus.m_rvalid_o, 96'(vt[k].e_rvl));
      chk($sformatf("v%0d_m_err", k),    bus.m_err_o & bus.m_rvalid_o, 96'(vt[k].e_err));
      chk($sformatf("v%0d_m_rdata", k),  bus.m_rdata_o,  vt[k].e_rdata);
      chk($sformatf("v%0d_s_req", k),    bus.s_req_o,    96'(vt[k].e_sreq));
      chk($sformatf("v%0d_s_addr", k),   bus.s_addr_o,   vt[k].e_saddr);
    end

    // reset while S0 waits on a response: the late response must be dropped
    @(posedge clk);
    #1;
    idle_inputs();
    bus.m_req_i  = 3'b001;
    bus.m_addr_i = {64'h0, 32'h200};
    bus.s_gnt_i  = 3'b001;
    @(negedge clk);
    chk("pre_rst_gnt", bus.m_gnt_o, 96'(3'b001));
    @(posedge clk);
    #1;
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_quiet", {bus.m_gnt_o, bus.m_rvalid_o, bus.s_req_o}, Z);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.s_rvalid_i = 3'b001;
    bus.s_rdata_i  = {64'h0, 32'h77};
    @(negedge clk);
    chk("late_rvalid", bus.m_rvalid_o, Z);
    // fresh contention on S1 after reset: pointer back at M0, M0 no longer busy
    @(posedge clk);
    #1;
    idle_inputs();
    bus.m_req_i  = 3'b011;
    bus.m_addr_i = {32'h0, S1A, S1A};
    bus.s_gnt_i  = 3'b010;
    @(negedge clk);
    chk("post_rst_gnt",  bus.m_gnt_o,  96'(3'b001));
    chk("post_rst_addr", bus.s_addr_o, {32'h0, S1A, 32'h0});
    @(posedge clk);
    #1;
    idle_inputs();
    bus.s_rvalid_i = 3'b010;
    bus.s_rdata_i  = {32'h0, 32'h99, 32'h0};
    @(negedge clk);
    chk("post_rst_rvalid", bus.m_rvalid_o, 96'(3'b001));
    chk("post_rst_rdata",  bus.m_rdata_o,  {64'h0, 32'h99});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
